// File: rtl/sr_latch_driver.sv
// Phase-ordered setup/strobe/hold driver for a gated SR latch, one command per handshake.
// Optional readback check of q_fb is enabled by defining SR_LATCH_DRIVER_READBACK_EN.
module sr_latch_driver #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  output logic       req_ready,
  output logic       s,
  output logic       r,
  output logic       en,
  input  logic       q_fb,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       exp_q
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned OP_W  = 2;

  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(1);

  localparam logic [OP_W-1:0] OP_CLR = OP_W'(2'b01);
  localparam logic [OP_W-1:0] OP_SET = OP_W'(2'b10);
  localparam logic [OP_W-1:0] OP_ILL = OP_W'(2'b11);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             ready_q, ready_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             expq_q, expq_d;
  logic             accept_c;
  logic             write_c;
  logic             drive_c;

  assign accept_c = req_valid && ready_q;

  // Outputs are decoded from the next state so they register in step with state_q.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    write_c = 1'b0;
    drive_c = 1'b0;
    ready_d = 1'b0;
    s_d     = 1'b0;
    r_d     = 1'b0;
    en_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    expq_d  = expq_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          op_d = req_op;
          if (req_op == OP_SET || req_op == OP_CLR) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    write_c = (op_d == OP_SET) || (op_d == OP_CLR);
    drive_c = write_c &&
              ((state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD));

    ready_d = (state_d == ST_IDLE);
    s_d     = drive_c && (op_d == OP_SET);
    r_d     = drive_c && (op_d == OP_CLR);
    en_d    = write_c && (state_d == ST_STROBE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_RESP);
    err_d   = done_d && (op_d == OP_ILL);

`ifdef SR_LATCH_DRIVER_READBACK_EN
    // q_fb is sampled on the edge entering RESP, HOLD_CYCLES after en falls.
    if (done_d && write_c && (q_fb != (op_d == OP_SET))) begin
      err_d = 1'b1;
    end
`endif

    if (done_d && write_c) begin
      expq_d = (op_d == OP_SET);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      ready_q <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      expq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ready_q <= ready_d;
      s_q     <= s_d;
      r_q     <= r_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      expq_q  <= expq_d;
    end
  end

`ifndef SR_LATCH_DRIVER_READBACK_EN
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
`endif

  assign req_ready = ready_q;
  assign s         = s_q;
  assign r         = r_q;
  assign en        = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign exp_q     = expq_q;

  // Latch-safety properties of the drive pattern.
  a_sr_exclusive: assert property (@(posedge clk) disable iff (rst) !(s_q && r_q));
  a_en_in_strobe: assert property (@(posedge clk) disable iff (rst) en_q |-> (state_q == ST_STROBE));
  a_sr_stable_en: assert property (@(posedge clk) disable iff (rst)
                                   (en_q && $past(en_q)) |-> $stable({s_q, r_q}));

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with default phase lengths (1/2/1).
module tb_sr_latch_driver;

`ifdef SR_LATCH_DRIVER_READBACK_EN
  localparam logic RB_EN = 1'b1;
`else
  localparam logic RB_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_op;
  logic       q_fb;
  logic       req_ready;
  logic       s;
  logic       r;
  logic       en;
  logic       busy;
  logic       done;
  logic       err;
  logic       exp_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_latch_driver dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_ready (req_ready),
    .s         (s),
    .r         (r),
    .en        (en),
    .q_fb      (q_fb),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .exp_q     (exp_q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Latch-safety invariants sampled mid-cycle on every cycle out of reset.
  logic prev_s = 1'b0;
  logic prev_r = 1'b0;
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      prev_s = 1'b0;
      prev_r = 1'b0;
    end else begin
      checks++;
      if ((s & r) !== 1'b0) begin
        errors++;
        $display("FAIL inv_sr_exclusive: s=%b r=%b, required not both 1", s, r);
      end
      if (en === 1'b1) begin
        checks++;
        if ({s, r} !== {prev_s, prev_r}) begin
          errors++;
          $display("FAIL inv_sr_stable_en: s r=%b%b prev=%b%b, required unchanged while en=1",
                   s, r, prev_s, prev_r);
        end
      end
      prev_s = s;
      prev_r = r;
    end
  end

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'b10;
    q_fb      = 1'b0;
    tick();
    tick();
    checks++;
    if ({s, r, en, busy, done, err, exp_q, req_ready} !== 8'b0) begin
      errors++;
      $display("FAIL reset_state: s r en busy done err exp_q ready=%b, required 00000000",
               {s, r, en, busy, done, err, exp_q, req_ready});
    end
    rst       = 1'b0;
    req_valid = 1'b0;
    tick();
    checks++;
    if ({req_ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release: ready busy done=%b, required 100", {req_ready, busy, done});
    end
  endtask

  // Set: s for cycles 1..4, en in cycles 2..3, done/exp_q update in cycle 5.
  task automatic test_set();
    logic [5:0] es;
    logic [5:0] een;
    logic [5:0] ebusy;
    logic [5:0] edone;
    logic [7:0] got;
    logic [7:0] want;
    es    = 6'b001111;
    een   = 6'b000110;
    ebusy = 6'b011111;
    edone = 6'b010000;
    q_fb      = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'b10;
    tick();
    req_valid = 1'b0;
    req_op    = 2'b01;
    for (int c = 0; c < 6; c++) begin
      got  = {s, r, en, busy, done, req_ready, err, exp_q};
      want = {es[c], 1'b0, een[c], ebusy[c], edone[c], ~ebusy[c], 1'b0, (c >= 4)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL set_cycle%0d: s r en busy done ready err exp_q=%b, required %b",
                 c + 1, got, want);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [7:0] got;
    req_valid = 1'b1;
    req_op    = 2'b11;
    tick();
    req_valid = 1'b0;
    req_op    = 2'b00;
    got = {s, r, en, busy, done, req_ready, err, exp_q};
    checks++;
    if (got !== 8'b00011011) begin
      errors++;
      $display("FAIL illegal_resp: s r en busy done ready err exp_q=%b, required 00011011", got);
    end
    tick();
    got = {s, r, en, busy, done, req_ready, err, exp_q};
    checks++;
    if (got !== 8'b00000101) begin
      errors++;
      $display("FAIL illegal_after: s r en busy done ready err exp_q=%b, required 00000101", got);
    end
  endtask

  // Clear with q_fb stuck at 1: err in RESP only when readback is built in.
  task automatic test_clear_readback();
    logic [5:0] er;
    logic [5:0] een;
    logic [5:0] ebusy;
    logic [5:0] edone;
    logic [7:0] got;
    logic [7:0] want;
    er    = 6'b001111;
    een   = 6'b000110;
    ebusy = 6'b011111;
    edone = 6'b010000;
    q_fb      = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'b01;
    tick();
    req_valid = 1'b0;
    req_op    = 2'b10;
    for (int c = 0; c < 6; c++) begin
      got  = {s, r, en, busy, done, req_ready, err, exp_q};
      want = {1'b0, er[c], een[c], ebusy[c], edone[c], ~ebusy[c], edone[c] & RB_EN, (c < 4)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL clear_cycle%0d: s r en busy done ready err exp_q=%b, required %b",
                 c + 1, got, want);
      end
      tick();
    end
  endtask

  // No-op then set with req_valid held: second accept waits for req_ready.
  task automatic test_back_to_back();
    logic [5:0] es;
    logic [5:0] een;
    logic [5:0] ebusy;
    logic [5:0] edone;
    logic [7:0] got;
    logic [7:0] want;
    es    = 6'b001111;
    een   = 6'b000110;
    ebusy = 6'b011111;
    edone = 6'b010000;
    q_fb      = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'b00;
    tick();
    req_op = 2'b10;
    got = {s, r, en, busy, done, req_ready, err, exp_q};
    checks++;
    if (got !== 8'b00011000) begin
      errors++;
      $display("FAIL b2b_nop_resp: s r en busy done ready err exp_q=%b, required 00011000", got);
    end
    tick();
    got = {s, r, en, busy, done, req_ready, err, exp_q};
    checks++;
    if (got !== 8'b00000100) begin
      errors++;
      $display("FAIL b2b_idle_gap: s r en busy done ready err exp_q=%b, required 00000100", got);
    end
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      got  = {s, r, en, busy, done, req_ready, err, exp_q};
      want = {es[c], 1'b0, een[c], ebusy[c], edone[c], ~ebusy[c], 1'b0, (c >= 4)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL b2b_set_cycle%0d: s r en busy done ready err exp_q=%b, required %b",
                 c + 1, got, want);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_strobe();
    logic [6:0] got;
    req_valid = 1'b1;
    req_op    = 2'b10;
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if ({s, en, exp_q} !== 3'b111) begin
      errors++;
      $display("FAIL mid_pre_reset: s en exp_q=%b, required 111", {s, en, exp_q});
    end
    #1 rst = 1'b1;
    #1;
    got = {s, r, en, busy, done, exp_q, req_ready};
    checks++;
    if (got !== 7'b0) begin
      errors++;
      $display("FAIL mid_async_clear: s r en busy done exp_q ready=%b, required 0000000", got);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({req_ready, busy, done, exp_q} !== 4'b1000) begin
      errors++;
      $display("FAIL mid_post_release: ready busy done exp_q=%b, required 1000",
               {req_ready, busy, done, exp_q});
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({done, busy, s, r, en} !== 5'b0) begin
        errors++;
        $display("FAIL mid_no_done%0d: done busy s r en=%b, required 00000",
                 c, {done, busy, s, r, en});
      end
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_illegal();
    test_clear_readback();
    test_back_to_back();
    test_reset_mid_strobe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
# sr_latch_driver

Clocked command sequencer that drives the set/reset/enable side of a gated SR latch. It accepts one set, clear or no-op command per handshake and emits a phase-ordered setup, strobe and hold pattern on `s`/`r`/`en`, so the latch never sees `s=r=1`. Optionally it reads back the latch output `q` and flags a mismatch. It sits between a control FSM or register interface and a level-sensitive SR storage cell.

## Interface
- `SETUP_CYCLES`, default 1: cycles `s`/`r` are driven with `en=0` before the strobe; legal range 1..15.
- `STROBE_CYCLES`, default 2: cycles `en=1`; legal range 1..15.
- `HOLD_CYCLES`, default 1: cycles `s`/`r` are held with `en=0` after the strobe; legal range 1..15.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  command present.
- `req_op`  in  2  command: 00 no-op, 01 clear, 10 set, 11 illegal.
- `req_ready`  out  1  block can accept a command.
- `s`  out  1  latch set input.
- `r`  out  1  latch reset input.
- `en`  out  1  latch enable.
- `q_fb`  in  1  latch output readback, synchronous to `clk`.
- `busy`  out  1  command in flight.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle error pulse, coincident with `done`.
- `exp_q`  out  1  last value written by a completed set or clear.

## Operation
- Reset values: `s=0`, `r=0`, `en=0`, `busy=0`, `done=0`, `err=0`, `exp_q=0`, state IDLE. Outputs clear asynchronously on `rst` rise, including mid-command.
- `req_ready` is high only in IDLE with `rst` low.
- Acceptance occurs when `req_valid && req_ready` is true on a rising edge. `req_op` is captured at that edge; later changes to `req_op` are ignored.
- FSM states: IDLE, SETUP, STROBE, HOLD, RESP.
- IDLE:
  - op 01 or 10 goes to SETUP.
  - op 00 or 11 goes directly to RESP.
- SETUP: `s`/`r` = captured op (10 gives `s=1,r=0`; 01 gives `s=0,r=1`), `en=0`. Lasts SETUP_CYCLES, then STROBE.
- STROBE: `s`/`r` unchanged, `en=1`. Lasts STROBE_CYCLES, then HOLD.
- HOLD: `s`/`r` unchanged, `en=0`. Lasts HOLD_CYCLES, then RESP.
- RESP: one cycle, then IDLE.
  - `s=r=en=0`.
  - `done=1`.
  - `exp_q` updates to the written value for set or clear only.
- `err` in RESP:
  - 1 for op 11.
  - 1 on readback mismatch (see Configuration).
  - 0 otherwise.
- An illegal op (11) never drives `s`, `r` or `en` high.
- `busy=1` in SETUP, STROBE, HOLD and RESP.
- A 4-bit down-counter reloads on each phase entry; the phase advances when the count reaches 1.
- `s` and `r` are never both 1 in any cycle.
- `en` is never 1 outside STROBE.
- `s`/`r` never change while `en=1`.

## Timing
- All outputs are registered.
- Set/clear latency, accept edge to `done` cycle: SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES + 1 cycles (5 with defaults).
- No-op and illegal latency: 1 cycle.
- `req_ready` returns high in the cycle after RESP. Back-to-back issue is therefore one command per latency+1 cycles.
- `q_fb` is sampled on the edge that enters RESP, i.e. HOLD_CYCLES after `en` falls.
- Reset asserted mid-command aborts it: no `done` is produced, and `exp_q` returns to 0.
- `req_valid` asserted during reset is ignored.

## Configuration
- Macro: `SR_LATCH_DRIVER_READBACK_EN`.
- Defined: in RESP after a set or clear, `err=1` if the sampled `q_fb` differs from the written value.
- Undefined: `q_fb` is unused and `err` reflects illegal ops only. Latency and all other behaviour are identical.

## Test plan
- Reset then set: after reset, issue op 10 → `s=1`, `r=0`, `en=0` for 1 cycle, then `en=1` for 2 cycles, then `en=0` for 1 cycle. `done=1`, `err=0`, `exp_q=1` 5 cycles after the accept.
- Clear with readback mismatch: with the macro defined, issue op 01 while `q_fb` is tied to 1 → `r` pulses per the phase pattern; in the RESP cycle `done=1` and `err=1`; `exp_q=0`.
- Illegal op: issue op 11 → `s`, `r` and `en` stay 0 throughout; one cycle later `done=1`, `err=1`; `exp_q` is unchanged.
- No-op and back-to-back: issue op 00 then immediately op 10 with `req_valid` held high → `done` pulses 1 cycle after the first accept; the second command is accepted once `req_ready` is high again; `req_ready` is 0 while `busy=1`.
- Reset mid-strobe: assert `rst` while `en=1` → `s`, `r`, `en`, `busy` and `exp_q` go to 0 asynchronously; no `done` follows; `req_ready` becomes 1 in the first cycle after `rst` falls.
- Invariant check across all runs: `s&r` is never 1, and `s`/`r` never toggle while `en=1`.
